// File: rtl/alu_op_sequencer.sv
// Purpose: issue-side controller for the combinational alu. It accepts one op, holds the alu operands, captures the result and computes the flags.
// Latency: 1 cycle from the accept edge to rsp_valid for add/sub/ror, and MUL_LAT cycles for mul. One request is in flight at a time.
// Backpressure: rsp_* are held while rsp_valid && !rsp_ready. req_ready is low from the accept until the response handshake.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake; req_op/req_a/req_b/req_tag payload
//   aluIn1/aluIn2/aluOp, aluOut     drive to / result from the combinational alu
//   rsp_valid/rsp_ready             response handshake; rsp_data/rsp_tag/rsp_n/z/c/v payload
//   op_count                        completed responses, free-running 16-bit wrap
module alu_op_sequencer #(
    parameter int MUL_LAT = 3,   // mul EXEC cycles, 1..15
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      aluIn1,
    output logic [31:0]      aluIn2,
    output logic [1:0]       aluOp,
    input  logic [31:0]      aluOut,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_n,
    output logic             rsp_z,
    output logic             rsp_c,
    output logic             rsp_v,
    output logic [15:0]      op_count
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT            state;
    logic [3:0]       execCnt;
    logic [TAG_W-1:0] tagReg;

    // Flag helpers. They work on the held operands, so they are valid at the capture edge.
    logic [32:0] addSum;
    logic [63:0] mulProd;
    logic        flagC;
    logic        flagV;
    logic        unusedBits;

    assign addSum     = {1'b0, aluIn1} + {1'b0, aluIn2};
    assign mulProd    = {32'b0, aluIn1} * {32'b0, aluIn2};
    // Only the carry and the high half of the product feed the flags.
    assign unusedBits = &{1'b0, addSum[31:0], mulProd[31:0]};

    always_comb begin
        flagC = 1'b0;
        flagV = 1'b0;
        case (aluOp)
            OP_ADD: begin
                flagC = addSum[32];
                flagV = (aluIn1[31] == aluIn2[31]) && (aluOut[31] != aluIn1[31]);
            end
            OP_SUB: begin
                // The alu computes in2 - in1; C means no borrow.
                flagC = (aluIn2 >= aluIn1);
                flagV = (aluIn1[31] != aluIn2[31]) && (aluOut[31] != aluIn2[31]);
            end
            OP_MUL: begin
                flagC = |mulProd[63:32];
            end
            OP_ROR: begin
                // A zero rotate amount leaves the carry clear.
                flagC = (aluIn1[4:0] != 5'd0) ? aluOut[31] : 1'b0;
            end
            default: begin
                flagC = 1'b0;
                flagV = 1'b0;
            end
        endcase
    end

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            execCnt   <= 4'd0;
            tagReg    <= '0;
            aluIn1    <= 32'd0;
            aluIn2    <= 32'd0;
            aluOp     <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_tag   <= '0;
            rsp_n     <= 1'b0;
            rsp_z     <= 1'b0;
            rsp_c     <= 1'b0;
            rsp_v     <= 1'b0;
            op_count  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        aluOp   <= req_op;
                        // Mask the rotate amount so the alu sees only 0..31.
                        aluIn1  <= (req_op == OP_ROR) ? {27'b0, req_a[4:0]} : req_a;
                        aluIn2  <= req_b;
                        tagReg  <= req_tag;
                        execCnt <= (req_op == OP_MUL) ? MUL_CNT : 4'd1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (execCnt == 4'd1) begin
                        rsp_data  <= aluOut;
                        rsp_n     <= aluOut[31];
                        rsp_z     <= (aluOut == 32'd0);
                        rsp_c     <= flagC;
                        rsp_v     <= flagV;
                        rsp_tag   <= tagReg;
                        rsp_valid <= 1'b1;
                        execCnt   <= 4'd0;
                        state     <= RESP;
                    end else begin
                        execCnt <= execCnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: directed, table-driven bench for alu_op_sequencer, with a behavioural alu in the loop.
// Latency: outputs are sampled 1 ns after the rising edge, and inputs are driven at the same point.
// Backpressure: rsp_ready is driven explicitly by the bench, including one held-stall sequence.
module tb_alu_op_sequencer;
    localparam int MUL_LAT = 3;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      aluIn1;
    logic [31:0]      aluIn2;
    logic [1:0]       aluOp;
    logic [31:0]      aluOut;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_n, rsp_z, rsp_c, rsp_v;
    logic [15:0]      op_count;

    alu_op_sequencer #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .aluIn1(aluIn1), .aluIn2(aluIn2), .aluOp(aluOp), .aluOut(aluOut),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_c(rsp_c),
        .rsp_v(rsp_v), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural combinational alu: add, sub = in2-in1, mul (low word), ror in2 by in1[4:0].
    logic [63:0] tbProd;
    always_comb begin
        tbProd = {32'b0, aluIn1} * {32'b0, aluIn2};
        case (aluOp)
            2'b00:   aluOut = aluIn1 + aluIn2;
            2'b01:   aluOut = aluIn2 - aluIn1;
            2'b10:   aluOut = tbProd[31:0];
            default: aluOut = (aluIn2 >> aluIn1[4:0]) | (aluIn2 << (6'd32 - {1'b0, aluIn1[4:0]}));
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] expIn1;
        logic [31:0] expData;
        logic        expN, expZ, expC, expV;
        int          expLat;
    } vecT;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expCount = 16'd0;
    vecT         vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic runVec(input vecT v);
        int lat;
        check("req_ready before accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_tag   = v.tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("aluIn1 after accept", aluIn1, v.expIn1);
        check("aluIn2 after accept", aluIn2, v.b);
        check("aluOp after accept", 32'(aluOp), 32'(v.op));
        check("req_ready in EXEC", 32'(req_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!rsp_valid) begin
                check("aluIn1 stable in EXEC", aluIn1, v.expIn1);
                check("aluIn2 stable in EXEC", aluIn2, v.b);
            end
        end
        check("latency", 32'(lat), 32'(v.expLat));
        check("rsp_data", rsp_data, v.expData);
        check("rsp_tag", 32'(rsp_tag), 32'(v.tag));
        check("flags NZCV", {28'b0, rsp_n, rsp_z, rsp_c, rsp_v},
              {28'b0, v.expN, v.expZ, v.expC, v.expV});
        check("aluIn1 kept after capture", aluIn1, v.expIn1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        expCount++;
        check("rsp_valid after handshake", 32'(rsp_valid), 32'd0);
        check("op_count", 32'(op_count), 32'(expCount));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op     a             b             tag    expIn1        expData       N     Z     C     V    lat
        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000001, 5'h01, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[1] = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 5'h02, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[2] = '{2'b01, 32'h00000005, 32'h00000003, 5'h03, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[3] = '{2'b01, 32'h00000003, 32'h00000005, 5'h04, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[4] = '{2'b10, 32'h00010000, 32'h00010000, 5'h05, 32'h00010000, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 3};
        vecs[5] = '{2'b11, 32'h00000024, 32'h0000000F, 5'h1A, 32'h00000004, 32'hF0000000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[6] = '{2'b11, 32'h00000020, 32'h80000001, 5'h07, 32'h00000000, 32'h80000001, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[7] = '{2'b10, 32'h00000003, 32'h00000005, 5'h08, 32'h00000003, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[8] = '{2'b01, 32'h00000005, 32'h00000005, 5'h09, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[9] = '{2'b00, 32'h80000000, 32'h80000000, 5'h1F, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        #2;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset aluIn1", aluIn1, 32'd0);
        check("reset aluIn2", aluIn2, 32'd0);
        check("reset aluOp", 32'(aluOp), 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        check("reset rsp_tag/flags", {22'b0, rsp_tag, rsp_n, rsp_z, rsp_c, rsp_v}, 32'd0);
        check("reset op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) runVec(vecs[i]);

        // Held response: a competing request must not be consumed and nothing may move.
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'd1; req_b = 32'd2; req_tag = 5'h03;
        @(posedge clk); #1;
        req_op = 2'b10; req_a = 32'd100; req_b = 32'd200; req_tag = 5'h11;
        for (int w = 0; w < 40 && !rsp_valid; w++) begin
            @(posedge clk); #1;
        end
        check("stall rsp_valid", 32'(rsp_valid), 32'd1);
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("stall rsp_valid held", 32'(rsp_valid), 32'd1);
            check("stall rsp_data held", rsp_data, 32'd3);
            check("stall rsp_tag held", 32'(rsp_tag), 32'h03);
            check("stall req_ready low", 32'(req_ready), 32'd0);
            check("stall op_count held", 32'(op_count), 32'(expCount));
            check("stall aluIn1 not reloaded", aluIn1, 32'd1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        expCount++;
        check("stall release rsp_valid", 32'(rsp_valid), 32'd0);
        check("stall release op_count", 32'(op_count), 32'(expCount));

        // Reset while the mul is in EXEC: the op is dropped and the count is cleared.
        req_valid = 1'b1; req_op = 2'b10; req_a = 32'd7; req_b = 32'd9; req_tag = 5'h05;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid-exec rsp_valid before reset", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid-exec reset req_ready", 32'(req_ready), 32'd1);
        check("mid-exec reset op_count", 32'(op_count), 32'd0);
        check("mid-exec reset aluIn1", aluIn1, 32'd0);
        #1;
        rst_n = 1'b1;
        expCount = 16'd0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("post-reset no response", 32'(rsp_valid), 32'd0);
        end
        check("post-reset op_count", 32'(op_count), 32'd0);
        runVec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
